// File: rtl/unary_add_n.sv
// Unary accumulator/emitter: adds popcount(din) to a counter in accumulate mode
// and replays the stored total as a train of single-cycle dout pulses in emit mode.
module unary_add_n #(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             mode,
  input  logic [N_IN-1:0]  din,
  output logic             dout,
  output logic             carry,
  output logic             ovf,
  output logic             empty,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_q, dout_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic             overflow;

  // Popcount of the input lanes, widened so the add below cannot lose the carry
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      pop = pop + SUM_W'(din[i]);
    end
  end

  assign sum      = {1'b0, count_q} + pop;
  assign overflow = sum[CNT_W];

  // Next-state: clear beats the enable, a disabled cycle holds everything
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      dout_d  = 1'b0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (en) begin
      if (!mode) begin
        if (overflow && (SATURATE != 0)) begin
          count_d = CNT_MAX;
        end else begin
          count_d = sum[CNT_W-1:0];
        end
        carry_d = overflow;
        ovf_d   = ovf_q | overflow;
        dout_d  = 1'b0;
      end else begin
        carry_d = 1'b0;
        if (count_q != '0) begin
          dout_d  = 1'b1;
          count_d = count_q - CNT_W'(1);
        end else begin
          dout_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign dout    = dout_q;
  assign carry   = carry_q;
  assign ovf     = ovf_q;
  assign empty   = (count_q == '0);

endmodule

// File: tb/tb_unary_add_n.sv
// Directed bench for unary_add_n: a default instance driven from a vector table,
// plus 4-bit wrap and clamp instances exercised by hand-written sequences.
module tb_unary_add_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clear, mode;
  logic [3:0] din;

  logic        a_dout, a_carry, a_ovf, a_empty;
  logic [11:0] a_count;
  logic        w_dout, w_carry, w_ovf, w_empty;
  logic [3:0]  w_count;
  logic        s_dout, s_carry, s_ovf, s_empty;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unary_add_n #(.N_IN(4), .CNT_W(12), .SATURATE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .din(din),
    .dout(a_dout), .carry(a_carry), .ovf(a_ovf), .empty(a_empty), .count_o(a_count));

  unary_add_n #(.N_IN(4), .CNT_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .din(din),
    .dout(w_dout), .carry(w_carry), .ovf(w_ovf), .empty(w_empty), .count_o(w_count));

  unary_add_n #(.N_IN(4), .CNT_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .din(din),
    .dout(s_dout), .carry(s_carry), .ovf(s_ovf), .empty(s_empty), .count_o(s_count));

  typedef struct {
    logic        clr, en, mode;
    logic [3:0]  din;
    logic [11:0] cnt;
    logic        dout, carry, ovf, empty;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, e, m, input logic [3:0] d,
                              input int cnt, input logic dv, cv, ov);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.din = d;
    v.cnt = 12'(cnt); v.dout = dv; v.carry = cv; v.ovf = ov; v.empty = (cnt == 0);
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic c, e, m, input logic [3:0] d);
    clear = c; en = e; mode = m; din = d;
    @(posedge clk);
    #1;
  endtask

  // sel 1 = wrap instance, 2 = clamp instance
  task automatic expect_dut(input string nm, input int sel, input int cnt,
                            input logic dv, cv, ov);
    if (sel == 1) begin
      check({nm, "_count"}, sel, 32'(w_count), 32'(cnt));
      check({nm, "_dout"},  sel, 32'(w_dout),  32'(dv));
      check({nm, "_carry"}, sel, 32'(w_carry), 32'(cv));
      check({nm, "_ovf"},   sel, 32'(w_ovf),   32'(ov));
      check({nm, "_empty"}, sel, 32'(w_empty), 32'(cnt == 0));
    end else begin
      check({nm, "_count"}, sel, 32'(s_count), 32'(cnt));
      check({nm, "_dout"},  sel, 32'(s_dout),  32'(dv));
      check({nm, "_carry"}, sel, 32'(s_carry), 32'(cv));
      check({nm, "_ovf"},   sel, 32'(s_ovf),   32'(ov));
      check({nm, "_empty"}, sel, 32'(s_empty), 32'(cnt == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; mode = 1'b0; din = '0;

    // Basic add: 3 x popcount(1011) = 9, then 9 pulses, then idle
    for (int k = 1; k <= 3; k++) add(0, 1, 0, 4'b1011, 3 * k, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 1, 4'b0000, 9 - k, 1, 0, 0);
    add(0, 1, 1, 4'b0000, 0, 0, 0, 0);
    // Enable gating: load 5, two pulses, 3 paused cycles, 3 more pulses
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 4, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 5, 0, 0, 0);
    add(0, 1, 1, 4'b0000, 4, 1, 0, 0);
    add(0, 1, 1, 4'b0000, 3, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 4'b1111, 3, 1, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 1, 1, 4'b0000, 3 - k, 1, 0, 0);
    add(0, 1, 1, 4'b0000, 0, 0, 0, 0);
    // Mode interleave: 6, emit 2, add 3 -> 7, emit 7
    add(1, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 4, 0, 0, 0);
    add(0, 1, 0, 4'b0011, 6, 0, 0, 0);
    add(0, 1, 1, 4'b1111, 5, 1, 0, 0);
    add(0, 1, 1, 4'b0000, 4, 1, 0, 0);
    add(0, 1, 0, 4'b0111, 7, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(0, 1, 1, 4'b0000, 7 - k, 1, 0, 0);
    add(0, 1, 1, 4'b0000, 0, 0, 0, 0);
    // Clear with en low mid-emit, and en low holding idle state
    add(0, 1, 0, 4'b0011, 2, 0, 0, 0);
    add(0, 1, 1, 4'b0000, 1, 1, 0, 0);
    add(1, 0, 1, 4'b0000, 0, 0, 0, 0);

    #12;
    check("reset_count", 0, 32'(a_count), 32'd0);
    check("reset_empty", 0, 32'(a_empty), 32'd1);
    check("reset_flags", 0, 32'({a_dout, a_carry, a_ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].din);
      check("vec_count", i, 32'(a_count), 32'(vecs[i].cnt));
      check("vec_dout",  i, 32'(a_dout),  32'(vecs[i].dout));
      check("vec_carry", i, 32'(a_carry), 32'(vecs[i].carry));
      check("vec_ovf",   i, 32'(a_ovf),   32'(vecs[i].ovf));
      check("vec_empty", i, 32'(a_empty), 32'(vecs[i].empty));
    end

    // Wrap: preload 14, add 3 -> 1 with one-cycle carry and sticky ovf
    step(1, 0, 0, 4'b0000);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 4'b1111);
    step(0, 1, 0, 4'b0011);
    expect_dut("wrap_pre", 1, 14, 0, 0, 0);
    step(0, 1, 0, 4'b0111);
    expect_dut("wrap_ovf", 1, 1, 0, 1, 1);
    step(0, 1, 0, 4'b0000);
    expect_dut("wrap_zero", 1, 1, 0, 0, 1);
    step(0, 0, 0, 4'b1111);
    expect_dut("wrap_hold", 1, 1, 0, 0, 1);
    step(0, 1, 1, 4'b0000);
    expect_dut("wrap_emit", 1, 0, 1, 0, 1);
    step(1, 0, 1, 4'b0000);
    expect_dut("wrap_clear", 1, 0, 0, 0, 0);

    // Clamp: preload 13, add 4 twice -> stays 15 with carry each time, then 15 pulses
    for (int k = 0; k < 3; k++) step(0, 1, 0, 4'b1111);
    step(0, 1, 0, 4'b0001);
    expect_dut("sat_pre", 2, 13, 0, 0, 0);
    step(0, 1, 0, 4'b1111);
    expect_dut("sat_clamp1", 2, 15, 0, 1, 1);
    step(0, 1, 0, 4'b1111);
    expect_dut("sat_clamp2", 2, 15, 0, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      step(0, 1, 1, 4'b0000);
      expect_dut("sat_emit", 2, 15 - k, 1, 0, 1);
    end
    step(0, 1, 1, 4'b0000);
    expect_dut("sat_idle", 2, 0, 0, 0, 1);

    // Async reset mid-accumulate, observed before any further clock edge
    step(1, 0, 0, 4'b0000);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 4'b1111);
    expect_dut("rst_pre", 1, 0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_dut("rst_async_w", 1, 0, 0, 0, 0);
    expect_dut("rst_async_s", 2, 0, 0, 0, 0);
    check("rst_async_a", 0, 32'(a_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
